// File: rtl/reflet_fpu_arbiter.sv
// reflet_fpu_arbiter
// Two-way round-robin arbiter and sequencer in front of the Reflet FPU
// arithmetic unit. A granted request has its opcode/operands latched, the AU
// is held enabled until it reports ready (or a watchdog expires), and the
// result is returned with a one-cycle done pulse to the granted requester.
// After every operation the AU enable drops for one cycle so AU submodules
// restart cleanly.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/opcode/in1..3   request N (N = 0,1), valid held until ack
//   reqN_ack                   one-cycle pulse, request N operands latched
//   reqN_done                  one-cycle pulse, res_* valid for requester N
//   res_out/res_flag/res_err   result of the last completed operation
//   au_enable/opcode/in1..3    drive to the arithmetic unit
//   au_ready/au_out/au_flag    status and result from the arithmetic unit
module reflet_fpu_arbiter #(
  parameter int float_size = 32,
  parameter int timeout    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [5:0]            req0_opcode,
  input  logic [5:0]            req1_opcode,
  input  logic [float_size-1:0] req0_in1,
  input  logic [float_size-1:0] req0_in2,
  input  logic [float_size-1:0] req0_in3,
  input  logic [float_size-1:0] req1_in1,
  input  logic [float_size-1:0] req1_in2,
  input  logic [float_size-1:0] req1_in3,
  output logic                  req0_ack,
  output logic                  req1_ack,
  output logic                  req0_done,
  output logic                  req1_done,
  output logic [float_size-1:0] res_out,
  output logic                  res_flag,
  output logic                  res_err,
  output logic                  au_enable,
  output logic [5:0]            au_opcode,
  output logic [float_size-1:0] au_in1,
  output logic [float_size-1:0] au_in2,
  output logic [float_size-1:0] au_in3,
  input  logic                  au_ready,
  input  logic [float_size-1:0] au_out,
  input  logic                  au_flag
);

  // Counter holds the number of RUN cycles already spent without ready,
  // so it never exceeds timeout-1.
  localparam int CW = $clog2(timeout) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [5:0]              opc_q, opc_d;
  logic [float_size-1:0]   in1_q, in1_d;
  logic [float_size-1:0]   in2_q, in2_d;
  logic [float_size-1:0]   in3_q, in3_d;
  logic [float_size-1:0]   res_out_q, res_out_d;
  logic                    res_flag_q, res_flag_d;
  logic                    res_err_q, res_err_d;
  logic                    done0_q, done0_d;
  logic                    done1_q, done1_d;
  logic                    ack0, ack1;
  logic                    grant_idx;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    opc_d      = opc_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    in3_d      = in3_q;
    res_out_d  = res_out_q;
    res_flag_d = res_flag_q;
    res_err_d  = res_err_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    // Tie goes to the requester that was not served last; otherwise the
    // only valid one wins (req1_valid alone selects 1, req0 alone selects 0).
    grant_idx  = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          ack0    = ~grant_idx;
          ack1    = grant_idx;
          last_d  = grant_idx;
          gnt_d   = grant_idx;
          opc_d   = grant_idx ? req1_opcode : req0_opcode;
          in1_d   = grant_idx ? req1_in1    : req0_in1;
          in2_d   = grant_idx ? req1_in2    : req0_in2;
          in3_d   = grant_idx ? req1_in3    : req0_in3;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Ready wins over the watchdog on the last allowed cycle.
        if (au_ready) begin
          res_out_d  = au_out;
          res_flag_d = au_flag;
          res_err_d  = 1'b0;
          done0_d    = ~gnt_q;
          done1_d    = gnt_q;
          state_d    = ST_GAP;
        end else if (cnt_q == CW'(timeout - 1)) begin
          res_out_d  = '0;
          res_flag_d = 1'b0;
          res_err_d  = 1'b1;
          done0_d    = ~gnt_q;
          done1_d    = gnt_q;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      opc_q      <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      in3_q      <= '0;
      res_out_q  <= '0;
      res_flag_q <= 1'b0;
      res_err_q  <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      opc_q      <= opc_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      in3_q      <= in3_d;
      res_out_q  <= res_out_d;
      res_flag_q <= res_flag_d;
      res_err_q  <= res_err_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
    end
  end

  // Ack is combinational in the IDLE cycle; suppressed while reset is held
  // because the request would not be latched.
  assign req0_ack  = ack0 & ~reset;
  assign req1_ack  = ack1 & ~reset;
  assign req0_done = done0_q;
  assign req1_done = done1_q;
  assign res_out   = res_out_q;
  assign res_flag  = res_flag_q;
  assign res_err   = res_err_q;
  assign au_enable = (state_q == ST_RUN);
  assign au_opcode = opc_q;
  assign au_in1    = in1_q;
  assign au_in2    = in2_q;
  assign au_in3    = in3_q;

endmodule

// File: tb/tb_reflet_fpu_arbiter.sv
// Testbench for reflet_fpu_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-timing reference model.
module tb_reflet_fpu_arbiter;

  localparam int FS = 32;
  localparam int TO = 8;
  localparam logic [5:0] OP_ADD = 6'h01;

  logic          clk = 1'b0;
  logic          reset;
  logic          rq_valid [2];
  logic [5:0]    rq_op    [2];
  logic [FS-1:0] rq_a     [2];
  logic [FS-1:0] rq_b     [2];
  logic [FS-1:0] rq_c     [2];

  logic          req0_ack, req1_ack, req0_done, req1_done;
  logic [FS-1:0] res_out;
  logic          res_flag, res_err;
  logic          au_enable;
  logic [5:0]    au_opcode;
  logic [FS-1:0] au_in1, au_in2, au_in3;
  logic          au_ready;
  logic [FS-1:0] au_out;
  logic          au_flag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reflet_fpu_arbiter #(.float_size(FS), .timeout(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rq_valid[0]), .req1_valid(rq_valid[1]),
    .req0_opcode(rq_op[0]), .req1_opcode(rq_op[1]),
    .req0_in1(rq_a[0]), .req0_in2(rq_b[0]), .req0_in3(rq_c[0]),
    .req1_in1(rq_a[1]), .req1_in2(rq_b[1]), .req1_in3(rq_c[1]),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .req0_done(req0_done), .req1_done(req1_done),
    .res_out(res_out), .res_flag(res_flag), .res_err(res_err),
    .au_enable(au_enable), .au_opcode(au_opcode),
    .au_in1(au_in1), .au_in2(au_in2), .au_in3(au_in3),
    .au_ready(au_ready), .au_out(au_out), .au_flag(au_flag)
  );

  // ---------------- behavioural AU stand-in ----------------
  // Ready rises on enabled cycle number au_lat and stays up; a latency
  // above TO means the unit never answers within the watchdog window.
  int          au_lat = 1;
  int          run_cyc = 0;
  bit          au_ovr_en = 1'b0;
  logic [31:0] au_ovr_val = 32'h0;

  function automatic logic [31:0] au_mix(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    return a ^ {b[15:0], b[31:16]} ^ (c + {26'd0, op});
  endfunction

  always @(posedge clk) run_cyc <= au_enable ? run_cyc + 1 : 0;
  assign au_ready = au_enable && (run_cyc + 1 >= au_lat);
  assign au_out   = au_ovr_en ? au_ovr_val : au_mix(au_opcode, au_in1, au_in2, au_in3);
  assign au_flag  = au_in2[0] ^ au_opcode[0];

  // ---------------- helpers ----------------
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk1 ({tag, "/en"},    au_enable, 1'b0);
    chk32({tag, "/opc"},   {26'd0, au_opcode}, 32'h0);
    chk32({tag, "/in1"},   au_in1, 32'h0);
    chk32({tag, "/in2"},   au_in2, 32'h0);
    chk32({tag, "/in3"},   au_in3, 32'h0);
    chk32({tag, "/res"},   res_out, 32'h0);
    chk1 ({tag, "/flag"},  res_flag, 1'b0);
    chk1 ({tag, "/err"},   res_err, 1'b0);
    chk1 ({tag, "/done0"}, req0_done, 1'b0);
    chk1 ({tag, "/done1"}, req1_done, 1'b0);
    chk1 ({tag, "/ack0"},  req0_ack, 1'b0);
    chk1 ({tag, "/ack1"},  req1_ack, 1'b0);
  endtask

  // Issue one request from requester r starting in an IDLE cycle and follow
  // it cycle by cycle to the IDLE cycle after its done pulse. The requester
  // drops valid the cycle after the ack.
  task automatic do_op(input string tag, input int r, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input int lat, input logic [31:0] exp_out,
                       input logic exp_flag, input logic exp_err);
    int n;
    n = (lat <= TO) ? lat : TO;
    rq_op[r] = op; rq_a[r] = a; rq_b[r] = b; rq_c[r] = c;
    rq_valid[r] = 1'b1;
    au_lat = lat;
    settle();
    chk1({tag, "/ack"},      (r == 0) ? req0_ack : req1_ack, 1'b1);
    chk1({tag, "/ack_oth"},  (r == 0) ? req1_ack : req0_ack, 1'b0);
    chk1({tag, "/en_t0"},    au_enable, 1'b0);
    tick();
    rq_valid[r] = 1'b0;
    settle();
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        tick();
        settle();
      end
      chk1 ({tag, "/run_en"},   au_enable, 1'b1);
      chk32({tag, "/run_opc"},  {26'd0, au_opcode}, {26'd0, op});
      chk32({tag, "/run_in1"},  au_in1, a);
      chk32({tag, "/run_in2"},  au_in2, b);
      chk32({tag, "/run_in3"},  au_in3, c);
      chk1 ({tag, "/run_ack"},  req0_ack | req1_ack, 1'b0);
      chk1 ({tag, "/run_done"}, req0_done | req1_done, 1'b0);
    end
    tick();
    settle();
    chk1 ({tag, "/gap_en"},   au_enable, 1'b0);
    chk1 ({tag, "/done"},     (r == 0) ? req0_done : req1_done, 1'b1);
    chk1 ({tag, "/done_oth"}, (r == 0) ? req1_done : req0_done, 1'b0);
    chk1 ({tag, "/gap_ack"},  req0_ack | req1_ack, 1'b0);
    chk32({tag, "/res"},      res_out, exp_out);
    chk1 ({tag, "/flag"},     res_flag, exp_flag);
    chk1 ({tag, "/err"},      res_err, exp_err);
    tick();
    settle();
    chk1 ({tag, "/post_done"}, req0_done | req1_done, 1'b0);
    chk1 ({tag, "/post_ack"},  req0_ack | req1_ack, 1'b0);
    chk1 ({tag, "/post_en"},   au_enable, 1'b0);
  endtask

  // ---------------- random-phase model state ----------------
  int          free_at, ack_at, done_at, run_len, cur_r, g, lat, acked;
  bit          last_m;
  bit          drop_next [2];
  logic [5:0]  cur_op;
  logic [31:0] cur_a, cur_b, cur_c, exp_out;
  logic        exp_flag, exp_err, en_exp;

  initial begin
    reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rq_valid[r] = 1'b0; rq_op[r] = '0; rq_a[r] = '0; rq_b[r] = '0; rq_c[r] = '0;
      drop_next[r] = 1'b0;
    end

    // Reset state
    tick(); tick(); tick();
    settle();
    chk_reset_state("reset");
    reset = 1'b0;

    // Tie from reset with both requesters held valid: 0,1,0,1 every 3 cycles
    au_lat = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        rq_valid[0] = 1'b1; rq_op[0] = 6'h02; rq_a[0] = 32'h11; rq_b[0] = 32'h22; rq_c[0] = 32'h33;
        rq_valid[1] = 1'b1; rq_op[1] = 6'h03; rq_a[1] = 32'h44; rq_b[1] = 32'h55; rq_c[1] = 32'h66;
      end
      settle();
      chk1("tie/ack0",  req0_ack,  (c % 3 == 0) && ((c / 3) % 2 == 0));
      chk1("tie/ack1",  req1_ack,  (c % 3 == 0) && ((c / 3) % 2 == 1));
      chk1("tie/en",    au_enable, c % 3 == 1);
      chk1("tie/done0", req0_done, (c % 3 == 2) && ((c / 3) % 2 == 0));
      chk1("tie/done1", req1_done, (c % 3 == 2) && ((c / 3) % 2 == 1));
    end
    tick();
    rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
    settle();
    chk1("tie/idle_ack", req0_ack | req1_ack, 1'b0);

    // Single-cycle ADD on req0
    au_ovr_en = 1'b1; au_ovr_val = 32'h40400000;
    do_op("add", 0, OP_ADD, 32'h3F800000, 32'h40000000, 32'h0, 1,
          32'h40400000, 1'b0 ^ OP_ADD[0], 1'b0);

    // Multi-cycle op, ready on RUN cycle 5
    au_ovr_val = 32'h3E800000;
    do_op("multi", 1, 6'h05, 32'h3F000000, 32'h3F000001, 32'h12345678, 5,
          32'h3E800000, 1'b1 ^ 1'b1, 1'b0);
    au_ovr_en = 1'b0;

    // Watchdog: ready never arrives
    do_op("tmo", 0, 6'h3F, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADF00D, TO + 5,
          32'h0, 1'b0, 1'b1);

    // Ready on the last allowed RUN cycle counts as success
    do_op("tmo_edge", 1, 6'h07, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h00FF00FF, TO,
          au_mix(6'h07, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h00FF00FF), 1'b1 ^ 1'b1, 1'b0);

    // Reset during RUN cycle 3 drops the operation
    rq_op[1] = 6'h0A; rq_a[1] = 32'h1; rq_b[1] = 32'h2; rq_c[1] = 32'h3;
    rq_valid[1] = 1'b1; au_lat = TO + 5;
    settle();
    chk1("rst_run/ack1", req1_ack, 1'b1);
    tick(); rq_valid[1] = 1'b0; settle();
    tick(); settle();
    tick(); reset = 1'b1; settle();
    chk1("rst_run/en3", au_enable, 1'b1);
    tick(); settle();
    chk_reset_state("rst_run");
    reset = 1'b0;
    for (int c = 0; c < TO + 2; c++) begin
      tick(); settle();
      chk1("rst_run/no_done", req0_done | req1_done, 1'b0);
      chk1("rst_run/no_en",   au_enable, 1'b0);
    end
    do_op("rst_fresh1", 1, 6'h0B, 32'h01020304, 32'h05060708, 32'h090A0B0C, 2,
          au_mix(6'h0B, 32'h01020304, 32'h05060708, 32'h090A0B0C), 1'b0 ^ 1'b1, 1'b0);

    // Immediate tie after that: req0 wins, req1 follows three cycles later
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1; au_lat = 1;
    settle();
    chk1("tie2/ack0", req0_ack, 1'b1);
    chk1("tie2/ack1", req1_ack, 1'b0);
    tick(); rq_valid[0] = 1'b0; settle();
    tick(); settle();
    chk1("tie2/done0", req0_done, 1'b1);
    tick(); settle();
    chk1("tie2/ack1b", req1_ack, 1'b1);
    chk1("tie2/ack0b", req0_ack, 1'b0);
    tick(); rq_valid[1] = 1'b0; settle();
    tick(); settle();
    chk1("tie2/done1", req1_done, 1'b1);
    tick(); settle();

    // Withdrawal the cycle after ack: completes once, no second ack
    do_op("withdraw", 0, 6'h10, 32'h77777777, 32'h88888888, 32'h99999999, 3,
          au_mix(6'h10, 32'h77777777, 32'h88888888, 32'h99999999), 1'b0, 1'b0);
    tick(); settle();
    chk1("withdraw/no_ack", req0_ack | req1_ack, 1'b0);
    chk1("withdraw/no_done", req0_done | req1_done, 1'b0);

    // Randomized traffic against a transaction-timing model
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    free_at = 0; ack_at = -100; done_at = -100; run_len = 0; cur_r = 0; last_m = 1'b1;
    cur_op = '0; cur_a = '0; cur_b = '0; cur_c = '0;
    exp_out = '0; exp_flag = 1'b0; exp_err = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (drop_next[r]) begin
          rq_valid[r] = 1'b0;
          drop_next[r] = 1'b0;
        end
        if (!rq_valid[r] && $urandom_range(0, 2) == 0) begin
          rq_valid[r] = 1'b1;
          rq_op[r] = 6'($urandom_range(0, 63));
          rq_a[r] = $urandom(); rq_b[r] = $urandom(); rq_c[r] = $urandom();
        end
      end
      acked = -1;
      if (c >= free_at && (rq_valid[0] || rq_valid[1])) begin
        g = (rq_valid[0] && rq_valid[1]) ? (last_m ? 0 : 1) : (rq_valid[0] ? 0 : 1);
        lat = $urandom_range(1, TO + 3);
        au_lat = lat;
        run_len = (lat <= TO) ? lat : TO;
        ack_at = c; done_at = c + run_len + 1; free_at = done_at + 1;
        last_m = (g == 1); cur_r = g;
        cur_op = rq_op[g]; cur_a = rq_a[g]; cur_b = rq_b[g]; cur_c = rq_c[g];
        exp_err  = (lat > TO);
        exp_out  = exp_err ? 32'h0 : au_mix(cur_op, cur_a, cur_b, cur_c);
        exp_flag = exp_err ? 1'b0 : (cur_b[0] ^ cur_op[0]);
        drop_next[g] = 1'b1;
        acked = g;
      end
      settle();
      en_exp = (c > ack_at) && (c <= ack_at + run_len);
      chk1("rnd/ack0",  req0_ack,  acked == 0);
      chk1("rnd/ack1",  req1_ack,  acked == 1);
      chk1("rnd/en",    au_enable, en_exp);
      chk1("rnd/done0", req0_done, (c == done_at) && (cur_r == 0));
      chk1("rnd/done1", req1_done, (c == done_at) && (cur_r == 1));
      if (en_exp) begin
        chk32("rnd/opc", {26'd0, au_opcode}, {26'd0, cur_op});
        chk32("rnd/in1", au_in1, cur_a);
        chk32("rnd/in3", au_in3, cur_c);
      end
      if (c == done_at) begin
        chk32("rnd/res", res_out, exp_out);
        chk1 ("rnd/flag", res_flag, exp_flag);
        chk1 ("rnd/err",  res_err,  exp_err);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
